traffic_light_renderer: RTL and testbench
=========================================

Name: traffic_light_renderer

Overview:
- Pixel-pipeline stage that drives the 40x40 traffic-light sprite ROM and turns its 1-bit shape output into 24-bit RGB.
- Takes the VGA scan position and background colour. Computes sprite-relative coordinates for the ROM, then colours housing, red lamp and green lamp from the game's light state.
- Sits between the VGA pixel-coordinate/background generator and the VGA output register.
- Light changes take effect only on frame boundaries and are followed by a lamp blink.

Parameters:
- SPRITE_X0, 300, screen x of sprite top-left corner (0..600)
- SPRITE_Y0, 20, screen y of sprite top-left corner (0..440)
- BLINK_FRAMES, 32, frames of blinking after a light change (1..63)
- BLINK_BIT, 2, bit of blink counter selecting dark phase (lamp dark for 2^BLINK_BIT frames at a time)

Ports:
- clk  in  1  system pixel clock
- reset_n  in  1  synchronous, active-low reset
- pix_valid  in  1  current x/y/bg are an active-area pixel
- x  in  10  screen column 0..639
- y  in  9  screen row 0..479
- bg_rgb  in  24  background colour for this pixel {R,G,B}
- frame_start  in  1  one-cycle pulse at start of each frame
- light_green  in  1  game light request: 1 green, 0 red
- sprite_x  out  6  column address to sprite ROM
- sprite_y  out  6  row address to sprite ROM
- rom_pixel  in  1  ROM shape bit, combinational from sprite_x/sprite_y
- out_valid  out  1  pix_valid delayed 2 cycles
- out_rgb  out  24  final pixel colour, aligned with out_valid

Behaviour:
- Reset (reset_n=0 at posedge): all pipeline registers 0, out_valid=0, out_rgb=0, sprite_x=sprite_y=0, light_q=0 (red), blink_cnt=0.
  - Reset mid-stream flushes the pipeline. Outputs read 0 the cycle after reset is asserted.
- Stage 0 (comb):
  - dx = x - SPRITE_X0, dy = y - SPRITE_Y0, both 11-bit signed.
  - in_box = dx in [0,39] and dy in [0,39]. Negative values are out of box, with no wrap.
- Stage 1 (reg):
  - Registers valid1 <= pix_valid, in_box1, dx1[5:0], dy1[5:0], bg1.
  - sprite_x = in_box1 ? dx1 : 0; sprite_y = in_box1 ? dy1 : 0.
  - rom_pixel is consumed in the same cycle.
- Stage 2 (reg): out_valid <= valid1; out_rgb chosen from stage-1 values:
  - valid1=0 -> 000000.
  - !in_box1 or rom_pixel=0 -> bg1.
  - dx1 in 2..37 and dy1 in 4..15 (red lamp): lit and light_q=0 -> FF0000; otherwise 400000.
  - dx1 in 2..37 and dy1 in 19..30 (green lamp): lit and light_q=1 -> 00FF00; otherwise 004000.
  - any other drawn pixel (housing) -> 404040.
- Latency: exactly 2 cycles from pix_valid/x/y/bg_rgb to out_valid/out_rgb. No stalls; one pixel per cycle.
- Light latch: light_q <= light_green only on a frame_start cycle. Mid-frame changes of light_green have no visible effect until the next frame_start.
- Blink counter, updated on frame_start only:
  - light_green != light_q -> blink_cnt <= BLINK_FRAMES.
  - else blink_cnt != 0 -> blink_cnt - 1.
  - else hold at 0, with no underflow.
  - If frame_start coincides with a light change, the new value is latched and the counter loads in the same cycle.
- lit = (blink_cnt == 0) or (blink_cnt[BLINK_BIT] == 0). Only the active lamp blinks. The inactive lamp stays dim.
- frame_start during a valid pixel is legal. The pixel in flight uses the pre-update light_q/blink_cnt in stage 2 of that cycle.

Optional Feature:
- Macro TRAFFIC_LIGHT_BLINK_EN.
- Defined: blink counter and lit logic as above.
- Undefined: no blink counter is synthesised, lit is constant 1, and the active lamp is fully lit from the first frame after the change. BLINK_FRAMES and BLINK_BIT are ignored.

Test Plan:
- Border pixel: reset, light_green=0, drive pix_valid=1 at (300,20), bg=0000FF -> sprite_x=0, sprite_y=0 next cycle; out_rgb=404040, out_valid=1 two cycles after input.
- Lamps: (320,30) -> FF0000. (320,45) -> 004000. After frame_start with light_green=1 and blink elapsed: (320,30) -> 400000, (320,45) -> 00FF00.
- Out of box: (299,20), (340,20) and (300,60) -> out_rgb = bg_rgb (e.g. 123456); sprite_x=sprite_y=0. Inside box, ROM-transparent pixel (305,20+5) -> bg passthrough.
- Frame-aligned change and blink (macro defined): toggle light_green mid-frame, and the lamp is unchanged until frame_start. blink_cnt=32 is lit; counts 31..28 are dark, 27..24 lit, ..., 0 lit permanently. Macro undefined: lit on the first frame.
- Streaming: 640 consecutive valid pixels on row 30 -> 640 outputs, each exactly 2 cycles later. The bg/sprite boundaries fall at x=300 and x=339 with no skew. pix_valid=0 bubble -> out_valid=0, out_rgb=000000.
- Reset mid-stream: assert reset_n=0 during a sprite row -> next cycle out_valid=0, out_rgb=0, light_q red, blink_cnt 0. Release, and the first valid output appears 2 cycles after the first valid input.

Source files
------------

// File: rtl/traffic_light_renderer.sv
// Two-stage sprite colouring stage for the 40x40 traffic-light ROM.
// Define TRAFFIC_LIGHT_BLINK_EN to add the post-change lamp blink.
module traffic_light_renderer #(
  parameter int SPRITE_X0    = 300,
  parameter int SPRITE_Y0    = 20,
  parameter int BLINK_FRAMES = 32,
  parameter int BLINK_BIT    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_valid,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic [23:0] bg_rgb,
  input  logic        frame_start,
  input  logic        light_green,
  output logic [5:0]  sprite_x,
  output logic [5:0]  sprite_y,
  input  logic        rom_pixel,
  output logic        out_valid,
  output logic [23:0] out_rgb
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic        in_box;
    logic [5:0]  dx;
    logic [5:0]  dy;
    logic [23:0] bg;
  } s1_t;

  logic [STAGES:0]   vld_pipe;
  logic signed [10:0] dx0, dy0;
  logic              in_box0;
  s1_t               s1;
  logic              light_q;
  logic              lit;
  logic              lamp_col, red_row, grn_row;
  logic [23:0]       rgb_nxt;

  // Signed offsets so positions left of / above the sprite never wrap into the box
  assign dx0 = $signed({1'b0, x}) - $signed(11'(SPRITE_X0));
  assign dy0 = $signed({2'b00, y}) - $signed(11'(SPRITE_Y0));
  assign in_box0 = (dx0 >= 11'sd0) && (dx0 < 11'sd40) &&
                   (dy0 >= 11'sd0) && (dy0 < 11'sd40);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      out_rgb  <= '0;
      light_q  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], pix_valid};
      s1       <= '{in_box0, dx0[5:0], dy0[5:0], bg_rgb};
      out_rgb  <= rgb_nxt;
      if (frame_start) light_q <= light_green;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign sprite_x  = s1.in_box ? s1.dx : 6'd0;
  assign sprite_y  = s1.in_box ? s1.dy : 6'd0;

`ifdef TRAFFIC_LIGHT_BLINK_EN
  logic [5:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt <= '0;
    end else if (frame_start) begin
      if (light_green != light_q)  blink_cnt <= 6'(BLINK_FRAMES);
      else if (blink_cnt != 6'd0)  blink_cnt <= blink_cnt - 6'd1;
    end
  end

  assign lit = (blink_cnt == 6'd0) || !blink_cnt[BLINK_BIT];
`else
  assign lit = 1'b1;
`endif

  assign lamp_col = (s1.dx >= 6'd2)  && (s1.dx <= 6'd37);
  assign red_row  = (s1.dy >= 6'd4)  && (s1.dy <= 6'd15);
  assign grn_row  = (s1.dy >= 6'd19) && (s1.dy <= 6'd30);

  // Only the lamp matching light_q can light; the other is always dim
  always_comb begin
    rgb_nxt = 24'h000000;
    if (vld_pipe[0]) begin
      if (!s1.in_box || !rom_pixel)  rgb_nxt = s1.bg;
      else if (lamp_col && red_row)  rgb_nxt = (lit && !light_q) ? 24'hFF0000 : 24'h400000;
      else if (lamp_col && grn_row)  rgb_nxt = (lit &&  light_q) ? 24'h00FF00 : 24'h004000;
      else                           rgb_nxt = 24'h404040;
    end
  end
endmodule

// File: tb/tb_traffic_light_renderer.sv
// Directed bench for traffic_light_renderer: vector table plus hand sequences.
module tb_traffic_light_renderer;
  localparam int BLINK_FRAMES = 32;
  localparam int BLINK_BIT    = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_valid;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [23:0] bg_rgb;
  logic        frame_start;
  logic        light_green;
  logic [5:0]  sprite_x, sprite_y;
  logic        rom_pixel;
  logic        out_valid;
  logic [23:0] out_rgb;

  int checks = 0;
  int errors = 0;

  traffic_light_renderer dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .x(x), .y(y),
    .bg_rgb(bg_rgb), .frame_start(frame_start), .light_green(light_green),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .rom_pixel(rom_pixel),
    .out_valid(out_valid), .out_rgb(out_rgb)
  );

  always #5 clk = ~clk;

  // Sprite shape: solid except one transparent texel at (5,5)
  assign rom_pixel = !(sprite_x == 6'd5 && sprite_y == 6'd5);

  typedef struct {
    logic [9:0]  px;
    logic [8:0]  py;
    logic [23:0] bg;
    logic [5:0]  sx;
    logic [5:0]  sy;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic pix(input logic [9:0] px, input logic [8:0] py, input logic [23:0] bg,
                     input logic [5:0] esx, input logic [5:0] esy, input logic [23:0] ergb,
                     input int idx);
    pix_valid = 1'b1; x = px; y = py; bg_rgb = bg;
    step();
    chk("sprite_x", idx, 24'(sprite_x), 24'(esx));
    chk("sprite_y", idx, 24'(sprite_y), 24'(esy));
    pix_valid = 1'b0;
    step();
    chk("out_valid", idx, 24'(out_valid), 24'd1);
    chk("out_rgb", idx, out_rgb, ergb);
  endtask

  function automatic logic [23:0] expc(input int dx, input int dy, input logic [23:0] bg,
                                       input bit lq, input bit lt);
    if (dx < 0 || dx > 39 || dy < 0 || dy > 39) return bg;
    if (dx == 5 && dy == 5) return bg;
    if (dx >= 2 && dx <= 37 && dy >= 4 && dy <= 15)  return (lt && !lq) ? 24'hFF0000 : 24'h400000;
    if (dx >= 2 && dx <= 37 && dy >= 19 && dy <= 30) return (lt && lq)  ? 24'h00FF00 : 24'h004000;
    return 24'h404040;
  endfunction

  bit exp_lq;
  int exp_cnt;
  bit exp_lit;

  initial begin
    vecs[0]  = '{10'd300, 9'd20,  24'h0000FF, 6'd0,  6'd0,  24'h404040};
    vecs[1]  = '{10'd320, 9'd30,  24'h0000FF, 6'd20, 6'd10, 24'hFF0000};
    vecs[2]  = '{10'd320, 9'd45,  24'h0000FF, 6'd20, 6'd25, 24'h004000};
    vecs[3]  = '{10'd299, 9'd20,  24'h123456, 6'd0,  6'd0,  24'h123456};
    vecs[4]  = '{10'd340, 9'd20,  24'h123456, 6'd0,  6'd0,  24'h123456};
    vecs[5]  = '{10'd300, 9'd60,  24'h123456, 6'd0,  6'd0,  24'h123456};
    vecs[6]  = '{10'd305, 9'd25,  24'h123456, 6'd5,  6'd5,  24'h123456};
    vecs[7]  = '{10'd339, 9'd59,  24'h0000FF, 6'd39, 6'd39, 24'h404040};
    vecs[8]  = '{10'd301, 9'd24,  24'h0000FF, 6'd1,  6'd4,  24'h404040};
    vecs[9]  = '{10'd337, 9'd35,  24'h0000FF, 6'd37, 6'd15, 24'hFF0000};
    vecs[10] = '{10'd302, 9'd36,  24'h0000FF, 6'd2,  6'd16, 24'h404040};
    vecs[11] = '{10'd302, 9'd39,  24'h0000FF, 6'd2,  6'd19, 24'h004000};
    vecs[12] = '{10'd0,   9'd0,   24'hABCDEF, 6'd0,  6'd0,  24'hABCDEF};
    vecs[13] = '{10'd639, 9'd479, 24'h00AA55, 6'd0,  6'd0,  24'h00AA55};
    vecs[14] = '{10'd302, 9'd50,  24'h0000FF, 6'd2,  6'd30, 24'h004000};
    vecs[15] = '{10'd302, 9'd51,  24'h0000FF, 6'd2,  6'd31, 24'h404040};

    reset_n = 1'b0; pix_valid = 1'b0; x = '0; y = '0; bg_rgb = '0;
    frame_start = 1'b0; light_green = 1'b0;
    step(); step();
    chk("rst_out_valid", 0, 24'(out_valid), 24'd0);
    chk("rst_out_rgb", 0, out_rgb, 24'd0);
    chk("rst_sprite_x", 0, 24'(sprite_x), 24'd0);
    chk("rst_sprite_y", 0, 24'(sprite_y), 24'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++)
      pix(vecs[i].px, vecs[i].py, vecs[i].bg, vecs[i].sx, vecs[i].sy, vecs[i].rgb, i);

    // Mid-frame request change must stay invisible
    light_green = 1'b1;
    pix(10'd320, 9'd30, 24'h0, 6'd20, 6'd10, 24'hFF0000, 100);
    pix(10'd320, 9'd45, 24'h0, 6'd20, 6'd25, 24'h004000, 101);

    // Pixel leaving stage 2 on the frame_start edge sees the old light
    pix_valid = 1'b1; x = 10'd320; y = 9'd30; bg_rgb = 24'h0;
    step();
    pix_valid = 1'b0; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("inflight_rgb", 102, out_rgb, 24'hFF0000);
    exp_lq = 1'b1; exp_cnt = BLINK_FRAMES;

    // Blink sequence after the change (constant lit when the feature is off)
    for (int f = 0; f <= BLINK_FRAMES + 1; f++) begin
      if (f > 0) begin
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        if (exp_cnt != 0) exp_cnt--;
      end
`ifdef TRAFFIC_LIGHT_BLINK_EN
      exp_lit = (exp_cnt == 0) || (exp_cnt[BLINK_BIT] == 1'b0);
`else
      exp_lit = 1'b1;
`endif
      pix(10'd320, 9'd45, 24'h0, 6'd20, 6'd25, exp_lit ? 24'h00FF00 : 24'h004000, 200 + f);
      if (f < 2) pix(10'd320, 9'd30, 24'h0, 6'd20, 6'd10, 24'h400000, 300 + f);
    end

    // Full row streaming, one pixel per cycle, row 30 (dy=10)
    for (int c = 0; c <= 641; c++) begin
      if (c < 640) begin
        pix_valid = 1'b1; x = 10'(c); y = 9'd30; bg_rgb = 24'hA50000 ^ 24'(c);
      end else begin
        pix_valid = 1'b0;
      end
      step();
      if (c < 640)
        chk("stream_sx", c, 24'(sprite_x), (c >= 300 && c <= 339) ? 24'(c - 300) : 24'd0);
      if (c >= 1 && c <= 640) begin
        chk("stream_valid", c - 1, 24'(out_valid), 24'd1);
        chk("stream_rgb", c - 1, out_rgb,
            expc(c - 1 - 300, 10, 24'hA50000 ^ 24'(c - 1), 1'b1, 1'b1));
      end
      if (c == 641) begin
        chk("bubble_valid", c, 24'(out_valid), 24'd0);
        chk("bubble_rgb", c, out_rgb, 24'd0);
      end
    end

    // Reset in the middle of a sprite row
    pix_valid = 1'b1; x = 10'd310; y = 9'd30; bg_rgb = 24'h111111;
    step();
    x = 10'd311;
    step();
    x = 10'd312; reset_n = 1'b0;
    step();
    chk("midrst_valid", 0, 24'(out_valid), 24'd0);
    chk("midrst_rgb", 0, out_rgb, 24'd0);
    chk("midrst_sx", 0, 24'(sprite_x), 24'd0);
    chk("midrst_sy", 0, 24'(sprite_y), 24'd0);
    reset_n = 1'b1; pix_valid = 1'b0;
    step();
    chk("postrst_valid", 1, 24'(out_valid), 24'd0);
    pix_valid = 1'b1; x = 10'd320; y = 9'd30;
    step();
    chk("postrst_valid", 2, 24'(out_valid), 24'd0);
    pix_valid = 1'b0;
    step();
    chk("postrst_valid", 3, 24'(out_valid), 24'd1);
    chk("postrst_rgb", 3, out_rgb, 24'hFF0000);
    pix(10'd320, 9'd45, 24'h0, 6'd20, 6'd25, 24'h004000, 400);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix(10'd320, 9'd45, 24'h0, 6'd20, 6'd25, 24'h00FF00, 401);
    pix(10'd320, 9'd30, 24'h0, 6'd20, 6'd10, 24'h400000, 402);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
